// File: rtl/dds_freq_meter.sv
// Frequency meter for DDS sine/square inputs: times PERIODS hysteresis-qualified
// rising crossings and converts the span into a DDS frequency word by serial division.
module dds_freq_meter #(
  parameter int DATA_WIDTH  = 12,
  parameter int PHASE_WIDTH = 32,
  parameter int PERIODS     = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int HYST        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] wave_in,
  input  logic                         wave_valid,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [CNT_WIDTH-1:0]         period_cnt,
  output logic [PHASE_WIDTH-1:0]       fre_word
);

  localparam logic signed [DATA_WIDTH-1:0] HYST_POS = DATA_WIDTH'(HYST);
  localparam logic signed [DATA_WIDTH-1:0] HYST_NEG = -HYST_POS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] PER_CNT   = CNT_WIDTH'(PERIODS);
  localparam logic [7:0]           XING_LAST = 8'(PERIODS - 1);
  localparam int                   BW        = $clog2(PHASE_WIDTH);
  localparam logic [BW-1:0]        BIT_LAST  = BW'(PHASE_WIDTH - 1);
  localparam logic [BW-1:0]        BIT_ONE   = BW'(1);

  typedef enum logic [2:0] {IDLE, ARM, MEAS, DIV, DONE} state_t;

  state_t                 state;
  logic                   sq;
  logic                   xing;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [7:0]             xcnt;
  logic [CNT_WIDTH-1:0]   pc_r;
  logic                   to_r;
  logic [CNT_WIDTH-1:0]   rem;
  logic [PHASE_WIDTH-1:0] quo;
  logic [BW-1:0]          bit_idx;

  logic [CNT_WIDTH:0]     rem_sh;
  logic [CNT_WIDTH-1:0]   rem_diff;
  logic                   rem_ge;
  logic [CNT_WIDTH-1:0]   rem_nxt;

  // A result of exactly 2^PHASE_WIDTH or more cannot be represented, so clamp it.
  function automatic logic [PHASE_WIDTH-1:0] result_word(
    input logic                   to,
    input logic [CNT_WIDTH-1:0]   d,
    input logic [PHASE_WIDTH-1:0] q
  );
    logic [PHASE_WIDTH-1:0] r;
    if (to)
      r = '0;
    else if (d <= PER_CNT)
      r = '1;
    else
      r = q;
    return r;
  endfunction

  always_comb begin
    xing = wave_valid && !sq && (wave_in > HYST_POS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq <= 1'b0;
    end else if (wave_valid) begin
      if (wave_in > HYST_POS)
        sq <= 1'b1;
      else if (wave_in < HYST_NEG)
        sq <= 1'b0;
    end
  end

  // Restoring step: the dividend's upper part (PERIODS) is preloaded into rem,
  // then PHASE_WIDTH zero bits are shifted in one per cycle.
  always_comb begin
    rem_sh   = {rem, 1'b0};
    rem_diff = rem_sh[CNT_WIDTH-1:0] - pc_r;
    rem_ge   = rem_sh >= {1'b0, pc_r};
    rem_nxt  = rem_ge ? rem_diff : rem_sh[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      xcnt       <= '0;
      pc_r       <= '0;
      to_r       <= 1'b0;
      rem        <= '0;
      quo        <= '0;
      bit_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      period_cnt <= '0;
      fre_word   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            state <= ARM;
            cnt   <= '0;
            to_r  <= 1'b0;
          end
        end
        ARM: begin
          if (cnt == CNT_MAX) begin
            state <= DONE;
            to_r  <= 1'b1;
          end else if (xing) begin
            state <= MEAS;
            cnt   <= '0;
            xcnt  <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        MEAS: begin
          if (cnt == CNT_MAX) begin
            state <= DONE;
            to_r  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (xing) begin
              if (xcnt == XING_LAST) begin
                state   <= DIV;
                pc_r    <= cnt + CNT_ONE;
                rem     <= PER_CNT;
                bit_idx <= '0;
              end else begin
                xcnt <= xcnt + 8'd1;
              end
            end
          end
        end
        DIV: begin
          rem     <= rem_nxt;
          quo     <= {quo[PHASE_WIDTH-2:0], rem_ge};
          bit_idx <= bit_idx + BIT_ONE;
          if (bit_idx == BIT_LAST)
            state <= DONE;
        end
        DONE: begin
          done       <= 1'b1;
          timeout    <= to_r;
          period_cnt <= to_r ? CNT_MAX : pc_r;
          fre_word   <= result_word(to_r, pc_r, quo);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Bench for dds_freq_meter: randomized sine/square stimulus scored every cycle
// against a crossing-timing model, plus fixed-value checks and a timeout instance.
module tb_dds_freq_meter;

  localparam int DW    = 12;
  localparam int PW    = 32;
  localparam int PER   = 16;
  localparam int CW    = 32;
  localparam int HY    = 16;
  localparam int TO_CW = 16;
  localparam longint MAXC = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 wave_valid = 1'b0;
  logic signed [DW-1:0] wave_in = '0;
  logic                 busy, done, timeout;
  logic [CW-1:0]        period_cnt;
  logic [PW-1:0]        fre_word;

  logic                 to_rst_n = 1'b0;
  logic                 to_start = 1'b0;
  logic                 to_valid = 1'b1;
  logic signed [DW-1:0] to_wave = '0;
  logic                 to_busy, to_done, to_timeout;
  logic [TO_CW-1:0]     to_pc;
  logic [PW-1:0]        to_fw;

  dds_freq_meter #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW), .PERIODS(PER), .CNT_WIDTH(CW), .HYST(HY)) dut (
    .clk(clk), .rst_n(rst_n), .wave_in(wave_in), .wave_valid(wave_valid), .start(start),
    .busy(busy), .done(done), .timeout(timeout), .period_cnt(period_cnt), .fre_word(fre_word)
  );

  dds_freq_meter #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW), .PERIODS(PER), .CNT_WIDTH(TO_CW), .HYST(HY)) dut_to (
    .clk(clk), .rst_n(to_rst_n), .wave_in(to_wave), .wave_valid(to_valid), .start(to_start),
    .busy(to_busy), .done(to_done), .timeout(to_timeout), .period_cnt(to_pc), .fre_word(to_fw)
  );

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  int     dut_dones = 0;
  longint done_cyc = 0;
  bit     to_finished = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      if (fails >= 200) begin
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  endtask

  // Stimulus source: 0 DDS sine, 1 square +/-1000, 2 noise +/-10, 3 zero.
  int          mode = 3;
  int          vmode = 0;
  logic [31:0] dds_fw = '0;
  int          sq_per = 100;

  function automatic logic signed [DW-1:0] sine(input logic [31:0] p);
    real r;
    r = 2047.0 * $sin(6.283185307179586 * real'(p) / 4294967296.0);
    return DW'($rtoi(r + ((r >= 0.0) ? 0.5 : -0.5)));
  endfunction

  initial begin
    logic [31:0] ph;
    int n;
    int v;
    ph = '0;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      case (mode)
        0: wave_in = sine(ph);
        1: wave_in = ((n % sq_per) < (sq_per / 2)) ? DW'(1000) : DW'(-1000);
        2: begin v = int'($urandom_range(0, 20)) - 10; wave_in = DW'(v); end
        default: wave_in = '0;
      endcase
      ph = ph + dds_fw;
      n++;
      case (vmode)
        0: wave_valid = 1'b1;
        1: wave_valid = n[0];
        default: wave_valid = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference model: tracks crossings by edge index and derives the result arithmetically.
  logic          m_sq = 0;
  bit            m_x, m_run = 0, m_pend = 0, m_armed = 0;
  longint        s_edge, arm_edge, done_edge, last_x = 0, m_n;
  int            k;
  logic          e_busy = 0, e_done = 0, e_to = 0, p_to;
  logic [CW-1:0] e_pc = '0, p_pc;
  logic [PW-1:0] e_fw = '0, p_fw;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_sq = 0; m_run = 0; m_pend = 0; m_armed = 0;
        e_busy = 0; e_done = 0; e_to = 0; e_pc = '0; e_fw = '0;
      end else begin
        m_x = wave_valid && !m_sq && (wave_in > HY);
        if (wave_valid) begin
          if (wave_in > HY) m_sq = 1;
          else if (wave_in < -HY) m_sq = 0;
        end
        e_done = 0;
        if (!m_run && !m_pend) begin
          e_busy = start;
          if (start) begin
            m_run = 1; m_armed = 0; s_edge = cyc; k = 0;
          end
        end else if (m_run) begin
          if ((!m_armed && (cyc - s_edge > MAXC)) || (m_armed && (cyc - arm_edge > MAXC))) begin
            p_to = 1; p_pc = CW'(MAXC); p_fw = '0;
            done_edge = cyc + 1; m_run = 0; m_pend = 1;
          end else if (m_x && !m_armed) begin
            m_armed = 1; arm_edge = cyc;
          end else if (m_x) begin
            k++;
            if (k == PER) begin
              m_n = cyc - arm_edge;
              last_x = cyc;
              p_to = 0;
              p_pc = CW'(m_n);
              p_fw = (m_n <= PER) ? '1 : PW'((longint'(PER) << PW) / m_n);
              done_edge = cyc + PW + 1;
              m_run = 0; m_pend = 1;
            end
          end
        end else if (cyc == done_edge) begin
          e_done = 1; e_to = p_to; e_pc = p_pc; e_fw = p_fw; m_pend = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("timeout", 64'(timeout), 64'(e_to));
      chk("period_cnt", 64'(period_cnt), 64'(e_pc));
      chk("fre_word", 64'(fre_word), 64'(e_fw));
      if (done === 1'b1) begin
        dut_dones++;
        done_cyc = cyc;
      end
    end
  end

  task automatic pulse_start;
    @(negedge clk); #2; start = 1'b1;
    @(negedge clk); #2; start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #3;
      if (done === 1'b1) got = 1;
    end
    chk(name, 64'(got), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_nominal(input string name);
    chk({name, "_pc"}, 64'(period_cnt), 64'd4096);
    chk({name, "_fw"}, 64'(fre_word), 64'h0100_0000);
    chk({name, "_to"}, 64'(timeout), 64'd0);
  endtask

  // Long-running timeout measurement on the narrow-counter instance.
  initial begin
    bit got;
    int v;
    got = 0;
    wait (to_rst_n === 1'b1);
    @(negedge clk); #2; to_start = 1'b1;
    @(negedge clk); #2; to_start = 1'b0;
    chk("035_busy", 64'(to_busy), 64'd1);
    for (int i = 0; i < 70000 && !got; i++) begin
      @(negedge clk); #1;
      v = int'($urandom_range(0, 20)) - 10;
      to_wave = DW'(v);
      #2;
      if (to_done === 1'b1) got = 1;
    end
    chk("035_done", 64'(got), 64'd1);
    chk("035_timeout", 64'(to_timeout), 64'd1);
    chk("035_fw", 64'(to_fw), 64'd0);
    chk("035_pc", 64'(to_pc), 64'hFFFF);
    to_finished = 1;
  end

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_pc", 64'(period_cnt), 64'd0);
    chk("rst_fw", 64'(fre_word), 64'd0);
    rst_n = 1'b1;
    to_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // DDS sine, 256-clk period
    mode = 0; dds_fw = 32'h0100_0000; vmode = 0;
    pulse_start();
    wait_done(6000, "033_done");
    chk_nominal("033");
    chk("033_latency", 64'(done_cyc - last_x), 64'd33);

    // square wave, 100-clk period
    mode = 1; sq_per = 100;
    pulse_start();
    wait_done(3000, "034_done");
    chk("034_pc", 64'(period_cnt), 64'd1600);
    chk("034_fw", 64'(fre_word), 64'h028F_5C28);

    // start re-pulsed while busy
    mode = 0; dds_fw = 32'h0100_0000;
    d0 = dut_dones;
    pulse_start();
    repeat (500) @(negedge clk);
    pulse_start();
    wait_done(6000, "036_done");
    repeat (60) @(negedge clk);
    chk("036_one_done", 64'(dut_dones - d0), 64'd1);
    chk_nominal("036");

    // reset in the middle of the division
    pulse_start();
    for (int i = 0; i < 6000 && !m_pend; i++) @(negedge clk);
    chk("037_reach_div", 64'(m_pend), 64'd1);
    repeat (10) @(negedge clk);
    #2; rst_n = 1'b0;
    d0 = dut_dones;
    #1;
    chk("037_busy", 64'(busy), 64'd0);
    chk("037_done", 64'(done), 64'd0);
    chk("037_pc", 64'(period_cnt), 64'd0);
    chk("037_fw", 64'(fre_word), 64'd0);
    repeat (3) @(negedge clk);
    #2; rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("037_no_done", 64'(dut_dones - d0), 64'd0);
    pulse_start();
    wait_done(6000, "037_redo_done");
    chk_nominal("037_redo");

    // alternate-cycle wave_valid
    vmode = 1;
    pulse_start();
    wait_done(6000, "038_done");
    chk_nominal("038");

    // randomized sine / square, random valid pattern
    for (int r = 0; r < 4; r++) begin
      mode = int'($urandom_range(0, 1));
      dds_fw = $urandom_range(32'd10737418, 32'd107374182);
      sq_per = int'($urandom_range(20, 300));
      vmode = int'($urandom_range(0, 2));
      pulse_start();
      wait_done(8000, "rand_done");
    end

    for (int i = 0; i < 80000 && !to_finished; i++) @(negedge clk);
    chk("035_finished", 64'(to_finished), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dds_freq_meter.md
DDS_FREQ_METER -- requirements
Module: dds_freq_meter

Interface
REQ-001 Parameter DATA_WIDTH, 12, width of the signed two's-complement input sample (same format as the DDS generator's wave_out_sin).
REQ-002 Parameter PHASE_WIDTH, 32, width of the measured frequency word (same scaling as the DDS generator's Fre_word).
REQ-003 Parameter PERIODS, 16, number of input periods averaged per measurement, range 1..255.
REQ-004 Parameter CNT_WIDTH, 32, width of the clock-cycle counter.
REQ-005 Parameter HYST, 16, hysteresis threshold magnitude in input LSBs, range 0..2^(DATA_WIDTH-1)-1.
REQ-006 clk  in  1  single clock; all logic is on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 wave_in  in  DATA_WIDTH  signed sample.
REQ-009 wave_valid  in  1  wave_in is sampled only in cycles where this is high.
REQ-010 start  in  1  single-cycle request to begin a measurement.
REQ-011 busy  out  1  high from the cycle after an accepted start through the done cycle.
REQ-012 done  out  1  one-cycle pulse when a result is valid.
REQ-013 timeout  out  1  qualifies done; the measurement found too few crossings.
REQ-014 period_cnt  out  CNT_WIDTH  clock cycles spanned by PERIODS input periods.
REQ-015 fre_word  out  PHASE_WIDTH  measured DDS frequency word.

Function
REQ-016 Hysteresis comparator sq: set to 1 when a valid wave_in > +HYST, cleared to 0 when a valid wave_in < -HYST, otherwise held; it runs continuously.
REQ-017 A crossing event is the cycle in which a valid sample changes sq from 0 to 1.
REQ-018 FSM states: IDLE, ARM, MEAS, DIV, DONE.
REQ-019 IDLE->ARM on start; start is ignored in every other state.
REQ-020 ARM: cycle counter cleared; ARM->MEAS on the first crossing event.
REQ-021 MEAS: counter increments every clk, and crossings are counted; on the PERIODS-th crossing after entry, period_cnt captures the number of clk edges since the arming crossing, then MEAS->DIV.
REQ-022 DIV: restoring division, one quotient bit per cycle, exactly PHASE_WIDTH cycles, computing fre_word = floor(PERIODS*2^PHASE_WIDTH / period_cnt).
REQ-023 If period_cnt <= PERIODS, fre_word saturates to 2^PHASE_WIDTH-1.
REQ-024 DONE: done=1 for exactly one cycle, then DONE->IDLE.
REQ-025 done rises PHASE_WIDTH+1 cycles after the clock edge that samples the final crossing.
REQ-026 Timeout: if the counter reaches 2^CNT_WIDTH-1 in ARM or MEAS, go directly to DONE with timeout=1, fre_word=0, and period_cnt=2^CNT_WIDTH-1.
REQ-027 fre_word, period_cnt, and timeout hold their values from the DONE cycle until the next DONE cycle.
REQ-028 Idle cycles of wave_valid do not stop the counter; only crossing detection is gated.
REQ-029 A crossing coincident with a counter timeout: timeout takes priority.

Reset
REQ-030 rst_n low asynchronously forces IDLE, sq=0, and all counters to 0, with busy=0, done=0, timeout=0, period_cnt=0, fre_word=0.
REQ-031 Reset asserted in any state, including mid-DIV, aborts the measurement without emitting done.
REQ-032 After rst_n deasserts, the first start is accepted normally.

Verification
REQ-033 DDS sine with Fre_word=0x01000000 (period 256 clk), wave_valid=1, pulse start -> period_cnt=4096, fre_word=0x01000000, timeout=0, done 33 cycles after the last crossing.
REQ-034 Square wave of ±1000 with period 100 clk -> period_cnt=1600, fre_word=0x028F5C28.
REQ-035 Noise within ±10 around 0 with HYST=16 and CNT_WIDTH=16 -> no crossings, then done with timeout=1, fre_word=0, period_cnt=0xFFFF.
REQ-036 start re-pulsed while busy -> ignored; exactly one done pulse results, with the REQ-033 values.
REQ-037 rst_n pulsed low during DIV -> all outputs 0 immediately, no done; a new start then gives the correct result.
REQ-038 Sine with Fre_word=0x01000000 but wave_valid low on alternate cycles -> result unchanged from REQ-033.
